// File: rtl/mem_wb_data_select_if.sv
// Bus bundle for the MEM/WB writeback data selector: pipeline controls, lane
// selects and external sources in; MEM/WB register, history and error flag out.
interface mem_wb_data_select_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int NUM_EXT    = 3,
  parameter int HIST_DEPTH = 2
);
  localparam int SEL_W = NUM_EXT + HIST_DEPTH * LANES;

  logic                                    stall;
  logic                                    flush;
  logic                                    in_valid;
  logic [LANES*SEL_W-1:0]                  sel;
  logic [LANES*NUM_EXT*DATA_WIDTH-1:0]     ext_data;
  logic [LANES*DATA_WIDTH-1:0]             wb_data;
  logic                                    wb_valid;
  logic [HIST_DEPTH*LANES*DATA_WIDTH-1:0]  hist_data;
  logic [HIST_DEPTH-1:0]                   hist_valid;
  logic                                    sel_err;

  modport master (
    output stall, flush, in_valid, sel, ext_data,
    input  wb_data, wb_valid, hist_data, hist_valid, sel_err
  );

  modport slave (
    input  stall, flush, in_valid, sel, ext_data,
    output wb_data, wb_valid, hist_data, hist_valid, sel_err
  );
endinterface

// File: rtl/mem_wb_data_select.sv
// MEM/WB writeback data selector with MEM/WB register and writeback history.
// Optional sticky one-hot select checking is enabled by macro MEM_WB_SEL_CHECK_EN.
module mem_wb_data_select #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int NUM_EXT    = 3,
  parameter int HIST_DEPTH = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  mem_wb_data_select_if.slave   bus
);
  localparam int SEL_W   = NUM_EXT + HIST_DEPTH * LANES;
  localparam int STAGE_W = LANES * DATA_WIDTH;
  localparam int HIST_W  = HIST_DEPTH * STAGE_W;

  logic [HIST_W-1:0]     hist_data_q, hist_data_d;
  logic [HIST_DEPTH-1:0] hist_valid_q, hist_valid_d;
  logic [STAGE_W-1:0]    sel_data;
  logic [LANES-1:0]      lane_onehot;

  // Source k of a lane sits at slice k: ext sources first, then the history
  // stages, whose flat layout already matches select bit NUM_EXT + d*LANES + j.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SEL_W-1:0]            lane_sel;
    logic [SEL_W*DATA_WIDTH-1:0] lane_src;
    logic [DATA_WIDTH-1:0]       lane_val;

    assign lane_sel = bus.sel[gi*SEL_W +: SEL_W];
    assign lane_src = {hist_data_q,
                       bus.ext_data[gi*NUM_EXT*DATA_WIDTH +: NUM_EXT*DATA_WIDTH]};
    assign lane_onehot[gi] = (lane_sel != '0) &&
                             ((lane_sel & (lane_sel - SEL_W'(1))) == '0);

    always_comb begin
      lane_val = '0;
      if (lane_onehot[gi]) begin
        for (int k = 0; k < SEL_W; k++) begin
          if (lane_sel[k]) lane_val = lane_src[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign sel_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_val;
  end

  // Flush still shifts so the bubble enters history; stall alone holds everything.
  always_comb begin
    hist_data_d  = hist_data_q;
    hist_valid_d = hist_valid_q;
    if (bus.flush || !bus.stall) begin
      for (int d = HIST_DEPTH - 1; d > 0; d--) begin
        hist_data_d[d*STAGE_W +: STAGE_W] = hist_data_q[(d-1)*STAGE_W +: STAGE_W];
        hist_valid_d[d]                   = hist_valid_q[d-1];
      end
      hist_data_d[STAGE_W-1:0] = bus.flush ? '0 : sel_data;
      hist_valid_d[0]          = bus.in_valid & ~bus.flush;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hist_data_q  <= '0;
      hist_valid_q <= '0;
    end else begin
      hist_data_q  <= hist_data_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  assign bus.hist_data  = hist_data_q;
  assign bus.hist_valid = hist_valid_q;
  assign bus.wb_data    = hist_data_q[STAGE_W-1:0];
  assign bus.wb_valid   = hist_valid_q[0];

`ifdef MEM_WB_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q | (bus.in_valid & ~bus.flush & ~(&lane_onehot));

  always_ff @(posedge clock_i) begin
    if (reset_i) sel_err_q <= 1'b0;
    else         sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_wb_data_select.sv
// Directed-vector bench for mem_wb_data_select at default parameters
// (DW=8, LANES=2, NUM_EXT=3, HIST_DEPTH=2).
module tb_mem_wb_data_select;
  localparam int DW    = 8;
  localparam int LN    = 2;
  localparam int NE    = 3;
  localparam int HD    = 2;
  localparam int SEL_W = NE + HD * LN;
`ifdef MEM_WB_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  mem_wb_data_select_if #(.DATA_WIDTH(DW), .LANES(LN), .NUM_EXT(NE), .HIST_DEPTH(HD)) bus ();

  mem_wb_data_select #(.DATA_WIDTH(DW), .LANES(LN), .NUM_EXT(NE), .HIST_DEPTH(HD)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input string tag);
    @(posedge clock);
    #1;
    $display("[%0t] %s: wb_data=%h wb_valid=%b hist=%h hist_valid=%b sel_err=%b",
             $time, tag, bus.wb_data, bus.wb_valid, bus.hist_data, bus.hist_valid, bus.sel_err);
  endtask

  task automatic drive(input logic [SEL_W-1:0] s0, input logic [SEL_W-1:0] s1,
                       input logic [7:0] l0e0, input logic [7:0] l0e1,
                       input logic [7:0] l1e0, input logic [7:0] l1e1,
                       input logic v);
    bus.sel                  = {s1, s0};
    bus.ext_data             = '0;
    bus.ext_data[0*DW +: DW] = l0e0;
    bus.ext_data[1*DW +: DW] = l0e1;
    bus.ext_data[3*DW +: DW] = l1e0;
    bus.ext_data[4*DW +: DW] = l1e1;
    bus.in_valid             = v;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive('0, '0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step("reset0");
    step("reset1");
    vecs++;
    if (bus.wb_data !== 16'h0000) begin errs++; $display("FAIL rst_wb_data: got %h expected 0000", bus.wb_data); end
    vecs++;
    if (bus.hist_valid !== 2'b00) begin errs++; $display("FAIL rst_hist_valid: got %b expected 00", bus.hist_valid); end
    vecs++;
    if (bus.hist_data !== 32'h0) begin errs++; $display("FAIL rst_hist_data: got %h expected 0", bus.hist_data); end
    vecs++;
    if (bus.sel_err !== 1'b0) begin errs++; $display("FAIL rst_sel_err: got %b expected 0", bus.sel_err); end
    reset = 1'b0;
  endtask

  task automatic test_forward;
    // lane0 <- ext0, lane1 <- ext1
    drive(7'b0000001, 7'b0000010, 8'hA5, 8'h77, 8'h66, 8'h3C, 1'b1);
    step("fwd0");
    vecs++;
    if (bus.wb_data !== 16'h3CA5) begin errs++; $display("FAIL fwd_data: got %h expected 3ca5", bus.wb_data); end
    vecs++;
    if (bus.wb_valid !== 1'b1) begin errs++; $display("FAIL fwd_valid: got %b expected 1", bus.wb_valid); end
    drive(7'b0000001, 7'b0000010, 8'h22, 8'h00, 8'h00, 8'h11, 1'b1);
    step("fwd1");
    chk32("fwd_hist", bus.hist_data, 32'h3CA5_1122);
    vecs++;
    if (bus.hist_valid !== 2'b11) begin errs++; $display("FAIL fwd_hist_valid: got %b expected 11", bus.hist_valid); end
  endtask

  task automatic test_swap;
    // Stage0 = 1122: lane0 reads stage0 lane1 (bit 4), lane1 reads stage0 lane0 (bit 3).
    drive(7'b0010000, 7'b0001000, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1);
    step("swap0");
    chk32("swap_stage0", bus.hist_data, 32'h1122_2211);
    // Stage1 = 1122: lane0 reads stage1 lane0 (bit 5), lane1 reads stage1 lane1 (bit 6).
    drive(7'b0100000, 7'b1000000, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1);
    step("swap1");
    chk32("swap_stage1", bus.hist_data, 32'h2211_1122);
    // Bubble advance: data stored, valid 0.
    drive(7'b0000010, 7'b0000001, 8'h00, 8'h9A, 8'h4B, 8'h00, 1'b0);
    step("bubble");
    chk32("bubble_hist", bus.hist_data, 32'h1122_4B9A);
    vecs++;
    if (bus.hist_valid !== 2'b10) begin errs++; $display("FAIL bubble_valid: got %b expected 10", bus.hist_valid); end
  endtask

  task automatic test_stall_flush;
    drive(7'b0000001, 7'b0000010, 8'hA5, 8'h00, 8'h00, 8'h3C, 1'b1);
    step("load0");
    drive(7'b0000001, 7'b0000010, 8'h22, 8'h00, 8'h00, 8'h11, 1'b1);
    step("load1");
    drive(7'b0000001, 7'b0000010, 8'hDE, 8'h00, 8'h00, 8'hAD, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk32("stall_hist", bus.hist_data, 32'h3CA5_1122);
      vecs++;
      if (bus.hist_valid !== 2'b11) begin errs++; $display("FAIL stall_valid: got %b expected 11", bus.hist_valid); end
    end
    bus.flush = 1'b1;
    step("flush");
    chk32("flush_hist", bus.hist_data, 32'h1122_0000);
    vecs++;
    if (bus.hist_valid !== 2'b10) begin errs++; $display("FAIL flush_valid: got %b expected 10", bus.hist_valid); end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
  endtask

  task automatic test_illegal;
    drive(7'b0000001, 7'b0000011, 8'h55, 8'h00, 8'hAA, 8'hBB, 1'b1);
    step("illegal");
    vecs++;
    if (bus.wb_data !== 16'h0055) begin errs++; $display("FAIL illegal_data: got %h expected 0055", bus.wb_data); end
    vecs++;
    if (bus.sel_err !== CHK) begin errs++; $display("FAIL illegal_err: got %b expected %b", bus.sel_err, CHK); end
    // Zero-hot lane0, legal lane1; sel_err must stay sticky.
    drive(7'b0000000, 7'b0000001, 8'h55, 8'h00, 8'h66, 8'h00, 1'b1);
    step("zerohot");
    vecs++;
    if (bus.wb_data !== 16'h6600) begin errs++; $display("FAIL zerohot_data: got %h expected 6600", bus.wb_data); end
    drive(7'b0000001, 7'b0000001, 8'h12, 8'h00, 8'h34, 8'h00, 1'b1);
    step("legal");
    vecs++;
    if (bus.wb_data !== 16'h3412) begin errs++; $display("FAIL legal_data: got %h expected 3412", bus.wb_data); end
    vecs++;
    if (bus.sel_err !== CHK) begin errs++; $display("FAIL sticky_err: got %b expected %b", bus.sel_err, CHK); end
  endtask

  task automatic test_reset_during_stall;
    bus.stall = 1'b1;
    reset = 1'b1;
    step("rst_stall");
    vecs++;
    if (bus.hist_data !== 32'h0) begin errs++; $display("FAIL rst_stall_data: got %h expected 0", bus.hist_data); end
    vecs++;
    if (bus.hist_valid !== 2'b00) begin errs++; $display("FAIL rst_stall_valid: got %b expected 00", bus.hist_valid); end
    vecs++;
    if (bus.sel_err !== 1'b0) begin errs++; $display("FAIL rst_stall_err: got %b expected 0", bus.sel_err); end
    reset = 1'b0;
    bus.stall = 1'b0;
    // Illegal select without in_valid: zeroed lane, no error.
    drive(7'b0000001, 7'b0000110, 8'h5A, 8'h00, 8'h01, 8'h02, 1'b0);
    step("illegal_nv");
    vecs++;
    if (bus.wb_data !== 16'h005A) begin errs++; $display("FAIL illegal_nv_data: got %h expected 005a", bus.wb_data); end
    vecs++;
    if (bus.sel_err !== 1'b0) begin errs++; $display("FAIL illegal_nv_err: got %b expected 0", bus.sel_err); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_swap();
    test_stall_flush();
    test_illegal();
    test_reset_during_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
